// File: rtl/instr_register_alu.sv
// instr_register_alu: DEPTH-entry {opcode, a, b} store with a 2-stage result pipeline.
// Optional macro IREG_RESULT_SAT_EN clamps ADD/SUB/MULT/DIV results instead of wrapping.
module instr_register_alu #(
    parameter  int OP_W   = 32,
    parameter  int DEPTH  = 32,
    parameter  int RES_W  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic [ADDR_W-1:0]      write_pointer,
    input  logic [2:0]             opcode,
    input  logic signed [OP_W-1:0] operand_a,
    input  logic signed [OP_W-1:0] operand_b,
    input  logic [ADDR_W-1:0]      read_pointer,
    output logic [2:0]             rd_opcode,
    output logic [OP_W-1:0]        rd_operand_a,
    output logic [OP_W-1:0]        rd_operand_b,
    output logic [RES_W-1:0]       rd_result,
    output logic                   rd_valid,
    output logic                   rd_div0,
    output logic                   wr_done,
    output logic [15:0]            wr_count
);
    typedef enum logic [2:0] {
        OP_ZERO, OP_PASSA, OP_PASSB, OP_ADD,
        OP_SUB, OP_MULT, OP_DIV, OP_MOD
    } op_e;

`ifdef IREG_RESULT_SAT_EN
    localparam int CALC_W = ((RES_W > 2*OP_W) ? RES_W : 2*OP_W) + 2;
    localparam logic signed [CALC_W-1:0] SAT_HI =
        (CALC_W'(1) <<< (RES_W-1)) - CALC_W'(1);
    localparam logic signed [CALC_W-1:0] SAT_LO = ~SAT_HI;
`else
    localparam int CALC_W = RES_W;
`endif

    logic                   s1_vld_q, s1_vld_d;
    logic [2:0]             s1_op_q, s1_op_d;
    logic [ADDR_W-1:0]      s1_ptr_q, s1_ptr_d;
    logic signed [OP_W-1:0] s1_a_q, s1_a_d;
    logic signed [OP_W-1:0] s1_b_q, s1_b_d;

    logic signed [CALC_W-1:0] ax, bx, bsafe, full;
    logic                     b_zero, div0_d, commit;
    logic [RES_W-1:0]         res_d;

    logic [2:0]       mem_op_q  [DEPTH];
    logic [OP_W-1:0]  mem_a_q   [DEPTH];
    logic [OP_W-1:0]  mem_b_q   [DEPTH];
    logic [RES_W-1:0] mem_res_q [DEPTH];
    logic             valid_q   [DEPTH];
    logic             div0_q    [DEPTH];

    logic [2:0]       rd_op_q, rd_op_d;
    logic [OP_W-1:0]  rd_a_q, rd_a_d;
    logic [OP_W-1:0]  rd_b_q, rd_b_d;
    logic [RES_W-1:0] rd_res_q, rd_res_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_dz_q, rd_dz_d;
    logic             wr_done_q, wr_done_d;
    logic [15:0]      wr_count_q, wr_count_d;

    // Stage 1: capture the incoming instruction when a write is requested
    always_comb begin
        s1_vld_d = load_en;
        s1_op_d  = s1_op_q;
        s1_ptr_d = s1_ptr_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        if (load_en) begin
            s1_op_d  = opcode;
            s1_ptr_d = write_pointer;
            s1_a_d   = operand_a;
            s1_b_d   = operand_b;
        end
    end

    // Stage 1 registers; reset flushes the in-flight write
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
        end
        s1_op_q  <= s1_op_d;
        s1_ptr_q <= s1_ptr_d;
        s1_a_q   <= s1_a_d;
        s1_b_q   <= s1_b_d;
    end

    // Stage 2: compute the sign-extended result and decide whether to commit
    always_comb begin
        ax     = CALC_W'(s1_a_q);
        bx     = CALC_W'(s1_b_q);
        b_zero = (s1_b_q == '0);
        bsafe  = b_zero ? CALC_W'(1) : bx;
        div0_d = 1'b0;
        full   = '0;
        case (op_e'(s1_op_q))
            OP_ZERO:  full = '0;
            OP_PASSA: full = ax;
            OP_PASSB: full = bx;
            OP_ADD:   full = ax + bx;
            OP_SUB:   full = ax - bx;
            OP_MULT:  full = ax * bx;
            OP_DIV: begin
                div0_d = b_zero;
                if (!b_zero) full = ax / bsafe;
            end
            OP_MOD: begin
                div0_d = b_zero;
                if (!b_zero) full = ax % bsafe;
            end
        endcase
        res_d = full[RES_W-1:0];
`ifdef IREG_RESULT_SAT_EN
        if (s1_op_q inside {OP_ADD, OP_SUB, OP_MULT, OP_DIV}) begin
            if (full > SAT_HI) res_d = SAT_HI[RES_W-1:0];
            else if (full < SAT_LO) res_d = SAT_LO[RES_W-1:0];
        end
`endif
        commit = s1_vld_q && (32'(s1_ptr_q) < DEPTH);
    end

    // Entry store: payload is never cleared, valid bits mask stale data
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                div0_q[i]  <= 1'b0;
            end
        end else if (commit) begin
            valid_q[s1_ptr_q]   <= 1'b1;
            div0_q[s1_ptr_q]    <= div0_d;
            mem_op_q[s1_ptr_q]  <= s1_op_q;
            mem_a_q[s1_ptr_q]   <= s1_a_q;
            mem_b_q[s1_ptr_q]   <= s1_b_q;
            mem_res_q[s1_ptr_q] <= res_d;
        end
    end

    // Read port and commit bookkeeping, computed from pre-edge state
    always_comb begin
        rd_op_d  = '0;
        rd_a_d   = '0;
        rd_b_d   = '0;
        rd_res_d = '0;
        rd_vld_d = 1'b0;
        rd_dz_d  = 1'b0;
        if (32'(read_pointer) < DEPTH) begin
            if (valid_q[read_pointer]) begin
                rd_op_d  = mem_op_q[read_pointer];
                rd_a_d   = mem_a_q[read_pointer];
                rd_b_d   = mem_b_q[read_pointer];
                rd_res_d = mem_res_q[read_pointer];
                rd_vld_d = 1'b1;
                rd_dz_d  = div0_q[read_pointer];
            end
        end
        wr_done_d  = commit;
        wr_count_d = wr_count_q;
        if (commit && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_op_q    <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            rd_res_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_dz_q    <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            rd_op_q    <= rd_op_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            rd_res_q   <= rd_res_d;
            rd_vld_q   <= rd_vld_d;
            rd_dz_q    <= rd_dz_d;
            wr_done_q  <= wr_done_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_opcode    = rd_op_q;
    assign rd_operand_a = rd_a_q;
    assign rd_operand_b = rd_b_q;
    assign rd_result    = rd_res_q;
    assign rd_valid     = rd_vld_q;
    assign rd_div0      = rd_dz_q;
    assign wr_done      = wr_done_q;
    assign wr_count     = wr_count_q;
endmodule

// File: tb/tb_instr_register_alu.sv
// tb_instr_register_alu: directed and random checks of instr_register_alu
// against an array/queue reference model (DEPTH=24 so out-of-range pointers exist).
module tb_instr_register_alu;
    localparam int OP_W   = 32;
    localparam int DEPTH  = 24;
    localparam int RES_W  = 64;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NPTR   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset, load_en;
    logic [ADDR_W-1:0] write_pointer, read_pointer;
    logic [2:0]        opcode;
    logic [OP_W-1:0]   operand_a, operand_b;
    logic [2:0]        rd_opcode;
    logic [OP_W-1:0]   rd_operand_a, rd_operand_b;
    logic [RES_W-1:0]  rd_result;
    logic              rd_valid, rd_div0, wr_done;
    logic [15:0]       wr_count;

    instr_register_alu #(.OP_W(OP_W), .DEPTH(DEPTH), .RES_W(RES_W)) dut (
        .clk(clk), .reset(reset), .load_en(load_en),
        .write_pointer(write_pointer), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .read_pointer(read_pointer),
        .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a),
        .rd_operand_b(rd_operand_b), .rd_result(rd_result),
        .rd_valid(rd_valid), .rd_div0(rd_div0),
        .wr_done(wr_done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         p;
        logic [2:0] op;
        int         a;
        int         b;
    } wr_t;

    logic [2:0]  m_op  [NPTR];
    int          m_a   [NPTR];
    int          m_b   [NPTR];
    longint      m_res [NPTR];
    bit          m_val [NPTR];
    bit          m_dz  [NPTR];
    int unsigned m_cnt;
    wr_t         pend[$];

    int errors = 0;
    int checks = 0;

    function automatic longint ref_res(input logic [2:0] op, input int a, input int b);
        longint la = a;
        longint lb = b;
        case (op)
            3'd1: return la;
            3'd2: return lb;
            3'd3: return la + lb;
            3'd4: return la - lb;
            3'd5: return la * lb;
            3'd6: return (b == 0) ? 64'sd0 : la / lb;
            3'd7: return (b == 0) ? 64'sd0 : la % lb;
            default: return 64'sd0;
        endcase
    endfunction

    function automatic int rnd_opnd();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 16) - 8;
            1: return 0;
            2: case ($urandom_range(0, 2))
                   0: return 32'h8000_0000;
                   1: return 32'h7FFF_FFFF;
                   default: return -1;
               endcase
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit ld, input int wp,
                       input logic [2:0] op, input int a, input int b, input int rp);
        logic [2:0]  e_op;
        logic [63:0] e_a, e_b, e_res;
        bit          e_val, e_dz, e_done;
        reset         = rst;
        load_en       = ld;
        write_pointer = ADDR_W'(wp);
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        read_pointer  = ADDR_W'(rp);
        e_op = '0; e_a = '0; e_b = '0; e_res = '0;
        e_val = 0; e_dz = 0; e_done = 0;
        if (rst) begin
            for (int i = 0; i < NPTR; i++) m_val[i] = 0;
            m_cnt = 0;
            pend.delete();
        end else begin
            if (rp < DEPTH && m_val[rp]) begin
                e_op  = m_op[rp];
                e_a   = 64'(unsigned'(m_a[rp]));
                e_b   = 64'(unsigned'(m_b[rp]));
                e_res = m_res[rp];
                e_val = 1;
                e_dz  = m_dz[rp];
            end
            if (pend.size() > 0) begin
                wr_t w = pend.pop_front();
                if (w.p < DEPTH) begin
                    e_done     = 1;
                    m_val[w.p] = 1;
                    m_op[w.p]  = w.op;
                    m_a[w.p]   = w.a;
                    m_b[w.p]   = w.b;
                    m_res[w.p] = ref_res(w.op, w.a, w.b);
                    m_dz[w.p]  = (w.op >= 3'd6) && (w.b == 0);
                    if (m_cnt < 16'hFFFF) m_cnt++;
                end
            end
            if (ld) pend.push_back('{p: wp, op: op, a: a, b: b});
        end
        @(negedge clk);
        chk("rd_opcode", 64'(rd_opcode), 64'(e_op));
        chk("rd_operand_a", 64'(rd_operand_a), e_a);
        chk("rd_operand_b", 64'(rd_operand_b), e_b);
        chk("rd_result", rd_result, e_res);
        chk("rd_valid", 64'(rd_valid), 64'(e_val));
        chk("rd_div0", 64'(rd_div0), 64'(e_dz));
        chk("wr_done", 64'(wr_done), 64'(e_done));
        chk("wr_count", 64'(wr_count), 64'(m_cnt));
    endtask

    initial begin
        m_cnt = 0;
        for (int i = 0; i < NPTR; i++) begin
            m_val[i] = 0; m_dz[i] = 0; m_op[i] = '0;
            m_a[i] = 0; m_b[i] = 0; m_res[i] = 0;
        end
        reset = 1'b1; load_en = 1'b0; write_pointer = '0; read_pointer = '0;
        opcode = '0; operand_a = '0; operand_b = '0;
        @(negedge clk);

        // reset for 3 cycles, then sweep every entry
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 3'd0, 0, 0, i);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 3'd0, 0, 0, i);
        chk("reset_count", 64'(wr_count), 64'd0);

        // ADD -7 + 3 at entry 5
        cyc(0, 1, 5, 3'd3, -7, 3, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);
        chk("add_done", 64'(wr_done), 64'd1);
        chk("add_count", 64'(wr_count), 64'd1);
        cyc(0, 0, 0, 3'd0, 0, 0, 5);
        chk("add_res", rd_result, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("add_done_clear", 64'(wr_done), 64'd0);

        // signed DIV/MOD and divide by zero
        cyc(0, 1, 1, 3'd6, -7, 2, 0);
        cyc(0, 1, 2, 3'd7, -7, 2, 0);
        cyc(0, 1, 3, 3'd6, 9, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 1);
        chk("div_res", rd_result, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_dz", 64'(rd_div0), 64'd0);
        cyc(0, 0, 0, 3'd0, 0, 0, 2);
        chk("mod_res", rd_result, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(0, 0, 0, 3'd0, 0, 0, 3);
        chk("div0_res", rd_result, 64'd0);
        chk("div0_flag", 64'(rd_div0), 64'd1);

        // full-width product
        cyc(0, 1, 4, 3'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 4);
        chk("mult_res", rd_result, 64'h3FFF_FFFF_0000_0001);

        // read on the commit edge sees old contents
        cyc(0, 1, 7, 3'd1, 11, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 7);
        chk("nobypass_valid", 64'(rd_valid), 64'd0);
        cyc(0, 0, 0, 3'd0, 0, 0, 7);
        chk("passa_res", rd_result, 64'd11);

        // reset right after a load drops it; out-of-range write is dropped
        cyc(0, 1, 9, 3'd2, 0, 42, 0);
        cyc(1, 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 9);
        chk("flush_valid", 64'(rd_valid), 64'd0);
        chk("flush_count", 64'(wr_count), 64'd0);
        cyc(0, 1, DEPTH, 3'd1, 5, 5, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, DEPTH);
        chk("oor_done", 64'(wr_done), 64'd0);
        chk("oor_count", 64'(wr_count), 64'd0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            bit rst_r = ($urandom_range(0, 99) == 0);
            bit ld_r  = ($urandom_range(0, 9) < 7);
            cyc(rst_r, ld_r, $urandom_range(0, NPTR-1), 3'($urandom_range(0, 7)),
                rnd_opnd(), rnd_opnd(), $urandom_range(0, NPTR-1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
